// File: rtl/sonic_ctrl_if.sv
// Sensor-side bundle of the ultrasonic ranging sequencer: control/echo inputs and
// result/status outputs, with master (stimulus/host) and slave (sequencer) views.
interface sonic_ctrl_if;
  logic        en;
  logic        echo;
  logic        trig;
  logic [31:0] echo_time;
  logic        e_done;
  logic        i_idle;
  logic        timeout;
  logic        busy;

  modport master (
    output en, echo,
    input  trig, echo_time, e_done, i_idle, timeout, busy
  );

  modport slave (
    input  en, echo,
    output trig, echo_time, e_done, i_idle, timeout, busy
  );
endinterface

// File: rtl/sonic_ctrl.sv
// Trigger/echo sequencer for one HC-SR04-style ranging channel: fires the trigger,
// times the echo in microseconds, and enforces timeout and hold-off between shots.
module sonic_ctrl #(
  parameter int unsigned CLKS_PER_US = 100,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 30000,
  parameter int unsigned HOLDOFF_US  = 60000
) (
  input  logic         clk,
  input  logic         rst_n,
  sonic_ctrl_if.slave  bus
);

  localparam int unsigned PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned CNT_W = 32;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_DONE,
    S_TOUT,
    S_HOLDOFF
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_state_chg;

  logic               r_echo_m;
  logic               r_echo_s;
  logic               r_echo_d;
  logic               w_rise;
  logic               w_fall;

  logic [PRE_W-1:0]   r_pre;
  logic [CNT_W-1:0]   r_us;
  logic [CNT_W-1:0]   r_echo_cnt;
  logic               w_us_tick;

  logic               r_trig;
  logic [CNT_W-1:0]   r_echo_time;
  logic               r_e_done;
  logic               r_timeout;
  logic               r_idle;
  logic               r_busy;

  // Two-flop synchroniser plus one delay stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_m <= 1'b0;
      r_echo_s <= 1'b0;
      r_echo_d <= 1'b0;
    end else begin
      r_echo_m <= bus.echo;
      r_echo_s <= r_echo_m;
      r_echo_d <= r_echo_s;
    end
  end

  assign w_rise    = r_echo_s & ~r_echo_d;
  assign w_fall    = ~r_echo_s & r_echo_d;
  assign w_us_tick = (r_pre == PRE_LAST);

  // Next-state decision; the rising/falling edge takes priority over the limit checks
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.en) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (w_us_tick && (r_us == TRIG_LAST)) w_state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (w_rise)                                w_state_nxt = S_MEASURE;
        else if (w_us_tick && (r_us == TOUT_LAST)) w_state_nxt = S_TOUT;
      end
      S_MEASURE: begin
        if (w_fall)                                                  w_state_nxt = S_DONE;
        else if (w_us_tick && r_echo_s && (r_echo_cnt == TOUT_LAST)) w_state_nxt = S_TOUT;
      end
      S_DONE:  w_state_nxt = S_HOLDOFF;
      S_TOUT:  w_state_nxt = S_HOLDOFF;
      S_HOLDOFF: begin
        if (w_us_tick && (r_us == HOLD_LAST)) w_state_nxt = bus.en ? S_TRIG : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);

  // State register, us timebase, echo counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pre       <= '0;
      r_us        <= '0;
      r_echo_cnt  <= '0;
      r_trig      <= 1'b0;
      r_echo_time <= '0;
      r_e_done    <= 1'b0;
      r_timeout   <= 1'b0;
      r_idle      <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      // Timebase restarts on every state entry so each us timer is entry-aligned
      if (w_state_chg || (r_state == S_IDLE)) begin
        r_pre <= '0;
        r_us  <= '0;
      end else if (w_us_tick) begin
        r_pre <= '0;
        r_us  <= r_us + CNT_W'(1);
      end else begin
        r_pre <= r_pre + PRE_W'(1);
      end

      if ((w_state_nxt == S_MEASURE) && (r_state != S_MEASURE)) begin
        r_echo_cnt <= '0;
      end else if ((r_state == S_MEASURE) && w_us_tick && r_echo_s) begin
        r_echo_cnt <= r_echo_cnt + CNT_W'(1);
      end

      if (w_state_nxt == S_DONE) r_echo_time <= r_echo_cnt;

      r_trig    <= (w_state_nxt == S_TRIG);
      r_e_done  <= (w_state_nxt == S_DONE);
      r_timeout <= (w_state_nxt == S_TOUT);
      r_idle    <= (w_state_nxt == S_IDLE);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.trig      = r_trig;
  assign bus.echo_time = r_echo_time;
  assign bus.e_done    = r_e_done;
  assign bus.timeout   = r_timeout;
  assign bus.i_idle    = r_idle;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sonic_ctrl.sv
// Bench for sonic_ctrl: a procedural reference of the shot sequence checked every
// cycle, plus hand-computed timing/value pins for the directed scenarios.
module tb_sonic_ctrl;

  localparam int unsigned CPU     = 4;
  localparam int unsigned TRIG_US = 10;
  localparam int unsigned TOUT_US = 100;
  localparam int unsigned HOLD_US = 20;

  localparam int TRIG_CLKS = TRIG_US * CPU;
  localparam int TOUT_CLKS = TOUT_US * CPU;
  localparam int HOLD_CLKS = HOLD_US * CPU;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sonic_ctrl_if ifc();

  sonic_ctrl #(
    .CLKS_PER_US (CPU),
    .TRIG_US     (TRIG_US),
    .TIMEOUT_US  (TOUT_US),
    .HOLDOFF_US  (HOLD_US)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, bit ok, longint act, longint lo, longint hi);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_trig = 0, m_idle = 1, m_busy = 0, m_done = 0, m_tout = 0;
  int m_et_lo = 0, m_et_hi = 0;
  bit m1 = 0, es = 0, ed = 0, m_pes = 0, m_ped = 0, m_en_pre = 0;

  task automatic m_reset();
    m_trig = 0; m_idle = 1; m_busy = 0; m_done = 0; m_tout = 0;
    m_et_lo = 0; m_et_hi = 0;
    m1 = 0; es = 0; ed = 0; m_pes = 0; m_ped = 0; m_en_pre = 0;
  endtask

  // One clock: capture pre-edge synchronised echo and en, then advance the sync chain
  task automatic step();
    @(posedge clk);
    m_en_pre = ifc.en;
    m_pes = es;
    m_ped = ed;
    ed = es;
    es = m1;
    m1 = ifc.echo;
  endtask

  task automatic model_run();
    int hc;
    bit rose, done, go;
    forever begin
      do step(); while (!m_en_pre);
      go = 1;
      while (go) begin
        m_idle = 0; m_busy = 1; m_trig = 1;
        repeat (TRIG_CLKS) step();
        m_trig = 0;
        rose = 0;
        for (int n = 0; n < TOUT_CLKS && !rose; n++) begin
          step();
          rose = m_pes && !m_ped;
        end
        done = 0;
        hc = 0;
        if (rose) begin
          while (1) begin
            step();
            if (!m_pes && m_ped) begin done = 1; break; end
            if (m_pes) hc++;
            if (hc >= TOUT_CLKS) break;
          end
        end
        if (done) begin
          m_done  = 1;
          m_et_lo = (hc / CPU > 0) ? hc / CPU - 1 : 0;
          m_et_hi = hc / CPU + 1;
        end else begin
          m_tout = 1;
        end
        step();
        m_done = 0; m_tout = 0;
        repeat (HOLD_CLKS) step();
        go = m_en_pre;
      end
      m_idle = 1; m_busy = 0;
    end
  endtask

  always begin
    m_reset();
    wait (rst_n === 1'b1);
    fork
      model_run();
      @(negedge rst_n);
    join_any
    disable fork;
  end

  // ---------------- per-cycle compare and event log ----------------
  int cyc = 0;
  int t_trig_rise = 0, t_trig_fall = 0, t_tout = 0, t_tout_fall = 0, trig_len = 0;
  int n_trig = 0, n_tout = 0, n_done = 0;
  bit p_trig = 0, p_tout = 0, p_done = 0;

  always @(negedge clk) begin
    bit ok;
    cyc++;
    ok = ((ifc.trig === m_trig) && (ifc.i_idle === m_idle) && (ifc.busy === m_busy) &&
          (ifc.e_done === m_done) && (ifc.timeout === m_tout) &&
          (ifc.echo_time >= 32'(m_et_lo)) && (ifc.echo_time <= 32'(m_et_hi))) === 1'b1;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL outputs cyc=%0d: got trig=%b idle=%b busy=%b done=%b tout=%b et=%0d, want trig=%b idle=%b busy=%b done=%b tout=%b et=%0d..%0d",
               cyc, ifc.trig, ifc.i_idle, ifc.busy, ifc.e_done, ifc.timeout, ifc.echo_time,
               m_trig, m_idle, m_busy, m_done, m_tout, m_et_lo, m_et_hi);
    end
    if (ifc.trig && !p_trig) begin t_trig_rise = cyc; n_trig++; end
    if (!ifc.trig && p_trig) begin t_trig_fall = cyc; trig_len = cyc - t_trig_rise; end
    if (ifc.timeout && !p_tout) begin t_tout = cyc; n_tout++; end
    if (!ifc.timeout && p_tout) t_tout_fall = cyc;
    if (ifc.e_done && !p_done) n_done++;
    p_trig = ifc.trig;
    p_tout = ifc.timeout;
    p_done = ifc.e_done;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // which: 0 trig high, 1 trig low, 2 e_done, 3 timeout
  task automatic wait_ev(int which, int budget, string name);
    int n = 0;
    bit hit = 0;
    while (!hit && n < budget) begin
      case (which)
        0:       hit = (ifc.trig === 1'b1);
        1:       hit = (ifc.trig === 1'b0);
        2:       hit = (ifc.e_done === 1'b1);
        3:       hit = (ifc.timeout === 1'b1);
        default: hit = 1'b1;
      endcase
      if (!hit) begin tick(); n++; end
    end
    if (!hit) check(name, hit, n, 0, budget - 1);
  endtask

  task automatic check_reset_outputs(string name);
    check({name, "_flags"}, {ifc.trig, ifc.i_idle, ifc.busy, ifc.e_done, ifc.timeout} === 5'b01000,
          {ifc.trig, ifc.i_idle, ifc.busy, ifc.e_done, ifc.timeout}, 5'b01000, 5'b01000);
    check({name, "_echo_time"}, ifc.echo_time === 32'd0, ifc.echo_time, 0, 0);
  endtask

  initial begin
    int n_trig_before;
    ifc.en   = 1'b0;
    ifc.echo = 1'b0;
    rst_n    = 1'b0;
    repeat (4) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_en0", ifc.i_idle === 1'b1 && ifc.trig === 1'b0, ifc.i_idle, 1, 1);

    // Shot 1: 40-clock trigger, then a 232-clock echo
    ifc.en = 1'b1;
    wait_ev(0, 10, "trig1_rise");
    check("idle_low_in_shot", ifc.i_idle === 1'b0 && ifc.busy === 1'b1, ifc.i_idle, 0, 0);
    wait_ev(1, 60, "trig1_fall");
    check("trig1_len", trig_len == 40, trig_len, 40, 40);
    repeat (20) tick();
    ifc.echo = 1'b1;
    repeat (232) tick();
    ifc.echo = 1'b0;
    wait_ev(2, 20, "done1_wait");
    check("echo_time_58", ifc.echo_time >= 32'd57 && ifc.echo_time <= 32'd59, ifc.echo_time, 57, 59);
    check("no_timeout_shot1", n_tout == 0, n_tout, 0, 0);

    // Shot 2: echo never rises
    wait_ev(0, 120, "trig2_rise");
    wait_ev(1, 60, "trig2_fall");
    wait_ev(3, 450, "tout2_wait");
    check("tout2_latency", (t_tout - t_trig_fall) == 400, t_tout - t_trig_fall, 400, 400);
    check("echo_time_kept", ifc.echo_time >= 32'd57 && ifc.echo_time <= 32'd59, ifc.echo_time, 57, 59);
    check("no_done_shot2", n_done == 1, n_done, 1, 1);

    // Shot 3: echo stuck high long enough to overrun the width limit
    wait_ev(0, 120, "trig3_rise");
    wait_ev(1, 60, "trig3_fall");
    ifc.echo = 1'b1;
    repeat (500) tick();
    ifc.echo = 1'b0;
    check("tout3_seen", n_tout == 2, n_tout, 2, 2);
    check("no_done_shot3", n_done == 1, n_done, 1, 1);
    check("holdoff_spacing", (t_trig_rise - t_tout_fall) == 80, t_trig_rise - t_tout_fall, 80, 80);

    // Shot 4: back-to-back, en dropped mid-measure
    wait_ev(1, 60, "trig4_fall");
    repeat (10) tick();
    ifc.echo = 1'b1;
    repeat (50) tick();
    ifc.en = 1'b0;
    repeat (50) tick();
    ifc.echo = 1'b0;
    wait_ev(2, 20, "done4_wait");
    check("echo_time_25", ifc.echo_time >= 32'd24 && ifc.echo_time <= 32'd26, ifc.echo_time, 24, 26);
    n_trig_before = n_trig;
    repeat (200) tick();
    check("idle_after_en0", ifc.i_idle === 1'b1 && ifc.busy === 1'b0, ifc.i_idle, 1, 1);
    check("no_more_trig", n_trig == n_trig_before, n_trig, n_trig_before, n_trig_before);

    // Shot 5: reset asserted mid-measure, then a fresh shot
    ifc.en = 1'b1;
    wait_ev(0, 10, "trig5_rise");
    wait_ev(1, 60, "trig5_fall");
    repeat (5) tick();
    ifc.echo = 1'b1;
    repeat (50) tick();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    tick();
    ifc.echo = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    wait_ev(0, 10, "trig6_rise");
    wait_ev(1, 60, "trig6_fall");
    check("trig6_len", trig_len == 40, trig_len, 40, 40);
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
